// File: rtl/alu_seq.sv
// Multi-cycle WIDTH-bit ALU: single-cycle ops complete with latency 1; MUL (shift-add)
// and SHLN/SHRN (one bit per cycle) iterate in EXEC. Result, high word and flags are registered.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             wb_en,
    output logic [3:0]       flags
);
    localparam int MSB = WIDTH - 1;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_CMP  = 5'd2;
    localparam logic [4:0] OP_ADC  = 5'd3;
    localparam logic [4:0] OP_SBC  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_XOR  = 5'd7;
    localparam logic [4:0] OP_MOV  = 5'd8;
    localparam logic [4:0] OP_NEG  = 5'd9;
    localparam logic [4:0] OP_COM  = 5'd10;
    localparam logic [4:0] OP_LSL  = 5'd11;
    localparam logic [4:0] OP_LSR  = 5'd12;
    localparam logic [4:0] OP_ROL  = 5'd13;
    localparam logic [4:0] OP_ROR  = 5'd14;
    localparam logic [4:0] OP_RLC  = 5'd15;
    localparam logic [4:0] OP_RRC  = 5'd16;
    localparam logic [4:0] OP_INC  = 5'd17;
    localparam logic [4:0] OP_DEC  = 5'd18;
    localparam logic [4:0] OP_MUL  = 5'd19;
    localparam logic [4:0] OP_SHLN = 5'd20;
    localparam logic [4:0] OP_SHRN = 5'd21;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [3:0]       flags_q, flags_d;
    logic             wb_en_q, wb_en_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [4:0]       mop_q, mop_d;

    // Single-cycle datapath: shared adder and subtractor at WIDTH+1 bits
    logic [WIDTH-1:0] add_y, sub_x, sub_y, sc_res;
    logic [WIDTH:0]   sum, dif;
    logic             add_ci, sub_bi, sc_c, sc_v, sc_wb, sc_sh;
    logic [3:0]       sc_flags;

    assign add_y  = (op == OP_INC) ? WIDTH'(1) : b;
    assign add_ci = (op == OP_ADC) & carry_in;
    assign sub_x  = (op == OP_NEG) ? '0 : a;
    assign sub_y  = (op == OP_DEC) ? WIDTH'(1) : ((op == OP_NEG) ? a : b);
    assign sub_bi = (op == OP_SBC) & carry_in;
    assign sum    = {1'b0, a} + {1'b0, add_y} + (WIDTH+1)'(add_ci);
    assign dif    = {1'b0, sub_x} - {1'b0, sub_y} - (WIDTH+1)'(sub_bi);

    always_comb begin
        sc_res = '0;
        sc_c   = flags_q[3];
        sc_v   = 1'b0;
        sc_wb  = 1'b1;
        sc_sh  = 1'b0;
        case (op)
            OP_ADD, OP_ADC, OP_INC: begin
                sc_res = sum[MSB:0];
                sc_c   = sum[WIDTH];
                sc_v   = (a[MSB] == add_y[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB, OP_CMP, OP_SBC, OP_DEC, OP_NEG: begin
                sc_res = dif[MSB:0];
                sc_c   = dif[WIDTH];
                sc_v   = (sub_x[MSB] != sub_y[MSB]) && (dif[MSB] != sub_x[MSB]);
                sc_wb  = (op != OP_CMP);
            end
            OP_AND: sc_res = a & b;
            OP_OR:  sc_res = a | b;
            OP_XOR: sc_res = a ^ b;
            OP_MOV: sc_res = b;
            OP_COM: sc_res = ~a;
            OP_LSL: begin sc_res = {a[MSB-1:0], 1'b0};     sc_c = a[MSB]; sc_sh = 1'b1; end
            OP_LSR: begin sc_res = {1'b0, a[MSB:1]};       sc_c = a[0];   sc_sh = 1'b1; end
            OP_ROL: begin sc_res = {a[MSB-1:0], a[MSB]};   sc_c = a[MSB]; sc_sh = 1'b1; end
            OP_ROR: begin sc_res = {a[0], a[MSB:1]};       sc_c = a[0];   sc_sh = 1'b1; end
            OP_RLC: begin sc_res = {a[MSB-1:0], carry_in}; sc_c = a[MSB]; sc_sh = 1'b1; end
            OP_RRC: begin sc_res = {carry_in, a[MSB:1]};   sc_c = a[0];   sc_sh = 1'b1; end
            default: sc_wb = 1'b0;
        endcase
        if (sc_sh) sc_v = a[MSB] ^ sc_res[MSB];
        sc_flags = sc_wb || (op == OP_CMP) ? {sc_c, sc_v, ~|sc_res, sc_res[MSB]} : flags_q;
    end

    // Iteration step: {acc, lo} shifts right one bit per cycle with the conditional add folded in
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_acc_n, mul_lo_n, sh_n;
    logic             sh_c;

    assign mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_acc_n = mul_sum[WIDTH:1];
    assign mul_lo_n  = {mul_sum[0], lo_q[MSB:1]};
    assign sh_n      = (mop_q == OP_SHLN) ? {lo_q[MSB-1:0], 1'b0} : {1'b0, lo_q[MSB:1]};
    assign sh_c      = (mop_q == OP_SHLN) ? lo_q[MSB] : lo_q[0];

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        hi_d        = hi_q;
        flags_d     = flags_q;
        wb_en_d     = wb_en_q;
        out_valid_d = 1'b0;
        acc_d       = acc_q;
        lo_d        = lo_q;
        mcand_d     = mcand_q;
        cnt_d       = cnt_q;
        mop_d       = mop_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (op == OP_MUL) begin
                        state_d = EXEC;
                        acc_d   = '0;
                        lo_d    = b;
                        mcand_d = a;
                        cnt_d   = SHW'(WIDTH - 1);
                        mop_d   = op;
                    end else if ((op == OP_SHLN || op == OP_SHRN) && b[SHW-1:0] != '0) begin
                        state_d = EXEC;
                        lo_d    = a;
                        cnt_d   = b[SHW-1:0] - 1'b1;
                        mop_d   = op;
                    end else if (op == OP_SHLN || op == OP_SHRN) begin
                        result_d    = a;
                        hi_d        = '0;
                        flags_d     = {2'b00, ~|a, a[MSB]};
                        wb_en_d     = 1'b1;
                        out_valid_d = 1'b1;
                    end else begin
                        result_d    = sc_res;
                        hi_d        = '0;
                        flags_d     = sc_flags;
                        wb_en_d     = sc_wb;
                        out_valid_d = 1'b1;
                    end
                end
            end
            EXEC: begin
                cnt_d = cnt_q - 1'b1;
                if (mop_q == OP_MUL) begin
                    acc_d = mul_acc_n;
                    lo_d  = mul_lo_n;
                end else begin
                    lo_d = sh_n;
                end
                if (cnt_q == '0) begin
                    state_d     = IDLE;
                    wb_en_d     = 1'b1;
                    out_valid_d = 1'b1;
                    if (mop_q == OP_MUL) begin
                        result_d = mul_lo_n;
                        hi_d     = mul_acc_n;
                        flags_d  = {|mul_acc_n, 1'b0, ~|{mul_acc_n, mul_lo_n}, mul_acc_n[MSB]};
                    end else begin
                        result_d = sh_n;
                        hi_d     = '0;
                        flags_d  = {sh_c, 1'b0, ~|sh_n, sh_n[MSB]};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            result_q    <= '0;
            hi_q        <= '0;
            flags_q     <= '0;
            wb_en_q     <= 1'b0;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            lo_q        <= '0;
            mcand_q     <= '0;
            cnt_q       <= '0;
            mop_q       <= '0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            hi_q        <= hi_d;
            flags_q     <= flags_d;
            wb_en_q     <= wb_en_d;
            out_valid_q <= out_valid_d;
            acc_q       <= acc_d;
            lo_q        <= lo_d;
            mcand_q     <= mcand_d;
            cnt_q       <= cnt_d;
            mop_q       <= mop_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign result_hi = hi_q;
    assign wb_en     = wb_en_q;
    assign flags     = flags_q;

endmodule
